// File: rtl/conv2d_stream.sv
// conv2d_stream
//   Streams one IMG_W x IMG_H image from a pixel memory in raster order, one
//   pixel per cycle, through two line buffers into a 3x3 window. It applies a
//   run-time loadable signed 3x3 kernel (correlation, zero padding) and writes
//   a same-sized result image back to memory. Each result is shifted right,
//   then clamped to 0 or made absolute (selected by mode), then saturated.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-low reset
//   start            begin a run (accepted only while ready=1)
//   mode             latched at start: 0 = clamp negatives to 0, 1 = |result|
//   coef_we          coefficient write strobe (accepted only while ready=1)
//   coef_addr        coefficient index 0..8, row-major; 9..15 ignored
//   coef_data        signed coefficient value
//   ReadAddress      pixel read address
//   d_in             pixel data for ReadAddress, same cycle
//   WriteAddress     result pixel address (raster index)
//   d_out            result pixel
//   WriteEnable      d_out/WriteAddress valid this cycle
//   ready            idle and accepting start/coef_we
//   done             one-cycle pulse after the last write
module conv2d_stream #(
  parameter int IMG_W  = 50,
  parameter int IMG_H  = 50,
  parameter int PIX_W  = 12,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 0,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              coef_we,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [ADDR_W-1:0] ReadAddress,
  input  logic [PIX_W-1:0]  d_in,
  output logic [ADDR_W-1:0] WriteAddress,
  output logic [PIX_W-1:0]  d_out,
  output logic              WriteEnable,
  output logic              ready,
  output logic              done
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int LAST  = NPIX + IMG_W + 2;
  localparam int CNT_W = $clog2(LAST + 1);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int ACC_W = PIX_W + COEF_W + 5;

  localparam logic [CNT_W-1:0]  N_LAST      = CNT_W'(LAST);
  localparam logic [CNT_W-1:0]  N_PIX       = CNT_W'(NPIX);
  localparam logic [CNT_W-1:0]  N_MAC_FIRST = CNT_W'(IMG_W + 1);
  localparam logic [CNT_W-1:0]  N_MAC_LAST  = CNT_W'(NPIX + IMG_W);
  localparam logic [COL_W-1:0]  C_LAST      = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  R_LAST      = ROW_W'(IMG_H - 1);
  localparam logic signed [ACC_W-1:0] PIX_MAX =
    {{(ACC_W - PIX_W){1'b0}}, {PIX_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   n;
  logic [CNT_W-1:0]   n_next;
  logic               mode_q;
  logic               running;

  logic signed [COEF_W-1:0] k [9];

  logic [PIX_W-1:0]   pix_in;
  logic [PIX_W-1:0]   lb_mid [IMG_W];
  logic [PIX_W-1:0]   lb_top [IMG_W];
  logic [COL_W-1:0]   ptr;
  logic [PIX_W-1:0]   new_col [3];
  logic [PIX_W-1:0]   win_l [3];
  logic [PIX_W-1:0]   win_m [3];
  logic [PIX_W-1:0]   tap_pix [9];

  logic               mac_fire;
  logic [ROW_W-1:0]   o_row;
  logic [COL_W-1:0]   o_col;
  logic [ADDR_W-1:0]  o_idx;
  logic [2:0]         row_ok;
  logic [2:0]         col_ok;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] acc_q;
  logic               acc_valid;
  logic [ADDR_W-1:0]  acc_addr;

  logic signed [ACC_W-1:0] res_sh;
  logic signed [ACC_W-1:0] res_mag;
  logic [PIX_W-1:0]   pix_res;

  assign n_next  = n + CNT_W'(1);
  assign running = (state == S_RUN);

  // Pixels are unsigned; widen with zeros so the signed multiply sees them
  // as non-negative.
  function automatic logic signed [ACC_W-1:0] pix_ext(input logic [PIX_W-1:0] p);
    return signed'({{(ACC_W - PIX_W){1'b0}}, p});
  endfunction

  function automatic logic signed [ACC_W-1:0] coef_ext(input logic signed [COEF_W-1:0] c);
    return {{(ACC_W - COEF_W){c[COEF_W-1]}}, c};
  endfunction

  // Control FSM. n counts the run cycles and also drives the read address,
  // which parks on the last pixel once the image has been fully read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      n           <= '0;
      ReadAddress <= '0;
      ready       <= 1'b1;
      done        <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_RUN;
            n           <= '0;
            ReadAddress <= '0;
            ready       <= 1'b0;
            mode_q      <= mode;
          end
        end
        S_RUN: begin
          if (n == N_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            n <= n_next;
            if (n_next < N_PIX) begin
              ReadAddress <= ADDR_W'(n_next);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Kernel registers reset to the identity kernel so an unconfigured engine
  // passes the image through unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) begin
        k[i] <= (i == 4) ? COEF_W'(1) : '0;
      end
    end else if (ready && coef_we && (coef_addr < 4'd9)) begin
      k[coef_addr] <= coef_data;
    end
  end

  // Once the whole image has been read, feed zeros so the bottom rows drain
  // out of the line buffers.
  always_comb begin
    pix_in     = (n < N_PIX) ? d_in : '0;
    new_col[0] = lb_top[ptr];
    new_col[1] = lb_mid[ptr];
    new_col[2] = pix_in;
  end

  // Line buffers hold the previous two image rows. ptr is the current column,
  // so lb_mid[ptr] is the pixel one row up and lb_top[ptr] two rows up. Their
  // stale contents only ever reach taps that the padding masks remove.
  always_ff @(posedge clk) begin
    if (running) begin
      lb_mid[ptr] <= pix_in;
      lb_top[ptr] <= lb_mid[ptr];
    end
  end

  // The MAC fires in the cycle in which the bottom-right tap of output o
  // arrives on d_in. The window for o is then the two registered columns plus
  // the incoming column. o_row/o_col track the centre pixel for padding.
  assign mac_fire = running && (n >= N_MAC_FIRST) && (n <= N_MAC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      o_row     <= '0;
      o_col     <= '0;
      o_idx     <= '0;
      acc_q     <= '0;
      acc_valid <= 1'b0;
      acc_addr  <= '0;
      for (int r = 0; r < 3; r++) begin
        win_l[r] <= '0;
        win_m[r] <= '0;
      end
    end else begin
      acc_valid <= mac_fire;
      if (!running) begin
        ptr   <= '0;
        o_row <= '0;
        o_col <= '0;
        o_idx <= '0;
      end else begin
        ptr <= (ptr == C_LAST) ? '0 : ptr + COL_W'(1);
        for (int r = 0; r < 3; r++) begin
          win_l[r] <= win_m[r];
          win_m[r] <= new_col[r];
        end
        if (mac_fire) begin
          acc_q    <= acc_next;
          acc_addr <= o_idx;
          o_idx    <= o_idx + ADDR_W'(1);
          if (o_col == C_LAST) begin
            o_col <= '0;
            o_row <= o_row + ROW_W'(1);
          end else begin
            o_col <= o_col + COL_W'(1);
          end
        end
      end
    end
  end

  // Padding masks come only from the centre position: index 0 is the row
  // above / column left, index 2 the row below / column right.
  always_comb begin
    row_ok = {o_row != R_LAST, 1'b1, o_row != '0};
    col_ok = {o_col != C_LAST, 1'b1, o_col != '0};
    for (int r = 0; r < 3; r++) begin
      tap_pix[r*3]     = win_l[r];
      tap_pix[r*3 + 1] = win_m[r];
      tap_pix[r*3 + 2] = new_col[r];
    end
    acc_next = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (row_ok[r] && col_ok[c]) begin
          acc_next = acc_next + (pix_ext(tap_pix[r*3 + c]) * coef_ext(k[r*3 + c]));
        end
      end
    end
  end

  // Post-processing: a floor shift, then rectify or take the absolute value,
  // then saturate to the pixel range.
  always_comb begin
    res_sh = acc_q >>> SHIFT;
    if (res_sh[ACC_W-1]) begin
      res_mag = mode_q ? -res_sh : '0;
    end else begin
      res_mag = res_sh;
    end
    pix_res = (res_mag > PIX_MAX) ? '1 : res_mag[PIX_W-1:0];
  end

  // Output register. The address and data hold their last values between
  // writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WriteEnable  <= 1'b0;
      WriteAddress <= '0;
      d_out        <= '0;
    end else begin
      WriteEnable <= acc_valid;
      if (acc_valid) begin
        WriteAddress <= acc_addr;
        d_out        <= pix_res;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream
//   Self-checking bench for conv2d_stream. A 50x50 instance covers the
//   identity, kernel, saturation, mode, control and reset scenarios. A 4x3
//   instance checks line buffer wrap against hand-computed values. Expected
//   writes are queued when a run is launched and popped as the DUT writes.
module tb_conv2d_stream;

  localparam int W     = 50;
  localparam int H     = 50;
  localparam int NPIX  = W * H;
  localparam int SW    = 4;
  localparam int SH    = 3;
  localparam int SNPIX = SW * SH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start, mode, coef_we;
  logic [3:0]  coef_addr;
  logic [7:0]  coef_data;
  logic [16:0] rd_addr, wr_addr;
  logic [11:0] d_in, d_out;
  logic        we, ready, done;

  logic        s_start, s_mode, s_coef_we;
  logic [3:0]  s_coef_addr;
  logic [7:0]  s_coef_data;
  logic [3:0]  s_rd_addr, s_wr_addr;
  logic [11:0] s_d_in, s_d_out;
  logic        s_we, s_ready, s_done;

  logic [11:0] img [131072];
  logic [11:0] img_s [16];
  int          ref_img [NPIX];
  int          ref_k [9];

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_q_s[$];

  int check_count = 0;
  int pass_count  = 0;
  int cyc = 0;
  int start_cyc, start_cyc_s;
  int wr_count, first_we_n, last_we_n;
  int wr_count_s, first_we_n_s, last_we_n_s;

  assign d_in   = img[rd_addr];
  assign s_d_in = img_s[s_rd_addr];

  conv2d_stream dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode         (mode),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .ReadAddress  (rd_addr),
    .d_in         (d_in),
    .WriteAddress (wr_addr),
    .d_out        (d_out),
    .WriteEnable  (we),
    .ready        (ready),
    .done         (done)
  );

  conv2d_stream #(
    .IMG_W  (SW),
    .IMG_H  (SH),
    .ADDR_W (4)
  ) dut_s (
    .clk          (clk),
    .rst          (rst),
    .start        (s_start),
    .mode         (s_mode),
    .coef_we      (s_coef_we),
    .coef_addr    (s_coef_addr),
    .coef_data    (s_coef_data),
    .ReadAddress  (s_rd_addr),
    .d_in         (s_d_in),
    .WriteAddress (s_wr_addr),
    .d_out        (s_d_out),
    .WriteEnable  (s_we),
    .ready        (s_ready),
    .done         (s_done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    check_count++;
    if (observed == expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Scoreboard for the 50x50 instance: every write must match the head of
  // the queue.
  always @(negedge clk) begin
    exp_t e;
    int   wn;
    if (we) begin
      wn = cyc - start_cyc - 1;
      if (wr_count == 0) first_we_n = wn;
      last_we_n = wn;
      wr_count++;
      if (exp_q.size() == 0) begin
        checkOutput("extra_write", wr_addr, -1);
      end else begin
        e = exp_q.pop_front();
        checkOutput("write_addr", wr_addr, e.addr);
        checkOutput("write_data", d_out, e.data);
      end
    end
  end

  // Scoreboard for the 4x3 instance.
  always @(negedge clk) begin
    exp_t e;
    int   wn;
    if (s_we) begin
      wn = cyc - start_cyc_s - 1;
      if (wr_count_s == 0) first_we_n_s = wn;
      last_we_n_s = wn;
      wr_count_s++;
      if (exp_q_s.size() == 0) begin
        checkOutput("small_extra_write", s_wr_addr, -1);
      end else begin
        e = exp_q_s.pop_front();
        checkOutput("small_write_addr", s_wr_addr, e.addr);
        checkOutput("small_write_data", s_d_out, e.data);
      end
    end
  end

  // Direct 2D reference: sum over in-bounds neighbours, rectify/abs, saturate.
  // SHIFT stays at its default of 0 on both instances.
  function automatic int model_px(input int r, input int c, input bit md);
    int acc = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W) begin
          acc += ref_img[(r + dr) * W + (c + dc)] * ref_k[(dr + 1) * 3 + (dc + 1)];
        end
      end
    end
    if (acc < 0) acc = md ? -acc : 0;
    if (acc > 4095) acc = 4095;
    return acc;
  endfunction

  task automatic fill_expected(input bit md);
    exp_t e;
    exp_q.delete();
    for (int o = 0; o < NPIX; o++) begin
      e.addr = o;
      e.data = model_px(o / W, o % W, md);
      exp_q.push_back(e);
    end
  endtask

  // kind 0: ramp, 1: constant val, 2: scrambled ramp
  task automatic set_image(input int kind, input int val);
    int p;
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0:       p = i % 4096;
        1:       p = val;
        default: p = (i * 7 + 3) % 4096;
      endcase
      img[i]     = 12'(p);
      ref_img[i] = p;
    end
  endtask

  task automatic set_kernel(input int k0, input int k1, input int k2,
                            input int k3, input int k4, input int k5,
                            input int k6, input int k7, input int k8);
    ref_k[0] = k0; ref_k[1] = k1; ref_k[2] = k2;
    ref_k[3] = k3; ref_k[4] = k4; ref_k[5] = k5;
    ref_k[6] = k6; ref_k[7] = k7; ref_k[8] = k8;
  endtask

  // Writes ref_k into the 50x50 DUT, leaving out index skip (-1 = none).
  task automatic write_kernel(input int skip);
    for (int i = 0; i < 9; i++) begin
      if (i != skip) begin
        @(posedge clk); #1;
        coef_we   = 1'b1;
        coef_addr = 4'(i);
        coef_data = 8'(ref_k[i]);
      end
    end
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  // Launches one run on the 50x50 instance. Optionally pulses start+coef_we
  // at n=pulse_at, asserts reset at n=rst_at, or writes a coefficient in the
  // start cycle itself.
  task automatic applyStimulus(input bit md, input int pulse_at, input int rst_at,
                               input bit late_coef, input int late_addr,
                               input int late_data, output int done_n);
    int n;
    bit got_done;
    bit aborted;
    done_n     = -1;
    wr_count   = 0;
    first_we_n = -1;
    last_we_n  = -1;
    @(negedge clk);
    checkOutput("ready_before_start", ready, 1);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = md;
    if (late_coef) begin
      coef_we   = 1'b1;
      coef_addr = 4'(late_addr);
      coef_data = 8'(late_data);
    end
    start_cyc = cyc;
    @(posedge clk); #1;
    start   = 1'b0;
    coef_we = 1'b0;
    mode    = ~md;
    n        = 0;
    got_done = 1'b0;
    aborted  = 1'b0;
    while (!got_done && !aborted && n < NPIX + W + 100) begin
      start     = (n == pulse_at);
      coef_we   = (n == pulse_at);
      coef_addr = 4'd4;
      coef_data = 8'd5;
      if (n == rst_at) begin
        rst = 1'b0;
        #1;
        checkOutput("abort_read_addr", rd_addr, 0);
        checkOutput("abort_write_addr", wr_addr, 0);
        checkOutput("abort_d_out", d_out, 0);
        checkOutput("abort_write_en", we, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_ready", ready, 1);
        exp_q.delete();
        set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst     = 1'b1;
        aborted = 1'b1;
      end else begin
        @(negedge clk);
        if (done) begin
          got_done = 1'b1;
          done_n   = n;
          checkOutput("ready_during_done", ready, 0);
        end
        @(posedge clk); #1;
        n++;
      end
    end
    start   = 1'b0;
    coef_we = 1'b0;
    if (!aborted) begin
      if (!got_done) begin
        checkOutput("done_timeout", 0, 1);
      end else begin
        @(negedge clk);
        checkOutput("ready_after_done", ready, 1);
        checkOutput("write_count", wr_count, NPIX);
        checkOutput("queue_left", exp_q.size(), 0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dn;
    int n;
    bit s_got_done;
    int s_done_n;
    int small_exp [12];
    exp_t e;

    start       = 1'b0;
    mode        = 1'b0;
    coef_we     = 1'b0;
    coef_addr   = '0;
    coef_data   = '0;
    s_start     = 1'b0;
    s_mode      = 1'b0;
    s_coef_we   = 1'b0;
    s_coef_addr = '0;
    s_coef_data = '0;
    wr_count    = 0;
    wr_count_s  = 0;
    start_cyc   = 0;
    start_cyc_s = 0;

    // Reset state.
    #2 rst = 1'b0;
    #1;
    $display("[TB] reset checks");
    checkOutput("reset_read_addr", rd_addr, 0);
    checkOutput("reset_write_addr", wr_addr, 0);
    checkOutput("reset_d_out", d_out, 0);
    checkOutput("reset_write_en", we, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_ready", ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Identity kernel from reset, ramp image, pipeline timing.
    $display("[TB] identity ramp and timing");
    set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
    set_image(0, 0);
    fill_expected(1'b0);
    applyStimulus(1'b0, -1, -1, 1'b0, 0, 0, dn);
    checkOutput("first_write_n", first_we_n, W + 3);
    checkOutput("last_write_n", last_we_n, NPIX + W + 2);
    checkOutput("done_n", dn, NPIX + W + 3);

    // All-ones kernel on a constant image: interior 81, corners 36, edges 54.
    $display("[TB] all-ones kernel, constant 9");
    set_kernel(1, 1, 1, 1, 1, 1, 1, 1, 1);
    write_kernel(-1);
    set_image(1, 9);
    fill_expected(1'b0);
    applyStimulus(1'b0, -1, -1, 1'b0, 0, 0, dn);

    // Saturation.
    $display("[TB] saturation");
    set_kernel(127, 127, 127, 127, 127, 127, 127, 127, 127);
    write_kernel(-1);
    set_image(1, 4095);
    fill_expected(1'b0);
    applyStimulus(1'b0, -1, -1, 1'b0, 0, 0, dn);

    // Negative centre tap in both modes.
    $display("[TB] negative kernel, mode 0 and 1");
    set_kernel(0, 0, 0, 0, -1, 0, 0, 0, 0);
    write_kernel(-1);
    set_image(1, 300);
    fill_expected(1'b0);
    applyStimulus(1'b0, -1, -1, 1'b0, 0, 0, dn);
    fill_expected(1'b1);
    applyStimulus(1'b1, -1, -1, 1'b0, 0, 0, dn);

    // Laplacian, absolute mode. The centre tap is written in the start cycle.
    $display("[TB] laplacian with coefficient write in start cycle");
    set_kernel(0, -1, 0, -1, 4, -1, 0, -1, 0);
    write_kernel(4);
    set_image(1, 100);
    fill_expected(1'b1);
    applyStimulus(1'b1, -1, -1, 1'b1, 4, 4, dn);

    // start/coef_we during a run are ignored.
    $display("[TB] control pulses during run");
    set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
    write_kernel(-1);
    set_image(0, 0);
    fill_expected(1'b0);
    applyStimulus(1'b0, 100, -1, 1'b0, 0, 0, dn);

    // Reset mid-run, which also restores the identity kernel.
    $display("[TB] reset mid-run and restart");
    set_kernel(1, 1, 1, 1, 1, 1, 1, 1, 1);
    write_kernel(-1);
    set_image(2, 0);
    fill_expected(1'b0);
    applyStimulus(1'b0, -1, 1000, 1'b0, 0, 0, dn);
    fill_expected(1'b0);
    applyStimulus(1'b0, -1, -1, 1'b0, 0, 0, dn);

    // 4x3 instance with a ramp and an all-ones kernel, using hand-computed
    // results.
    $display("[TB] small image line buffer wrap");
    small_exp = '{10, 18, 24, 18, 27, 45, 54, 39, 26, 42, 48, 34};
    for (int i = 0; i < SNPIX; i++) begin
      img_s[i] = 12'(i);
      e.addr   = i;
      e.data   = small_exp[i];
      exp_q_s.push_back(e);
    end
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      s_coef_we   = 1'b1;
      s_coef_addr = 4'(i);
      s_coef_data = 8'd1;
    end
    @(posedge clk); #1;
    s_coef_we    = 1'b0;
    wr_count_s   = 0;
    first_we_n_s = -1;
    last_we_n_s  = -1;
    @(posedge clk); #1;
    s_start     = 1'b1;
    s_mode      = 1'b0;
    start_cyc_s = cyc;
    @(posedge clk); #1;
    s_start    = 1'b0;
    n          = 0;
    s_got_done = 1'b0;
    s_done_n   = -1;
    while (!s_got_done && n < 100) begin
      @(negedge clk);
      if (s_done) begin
        s_got_done = 1'b1;
        s_done_n   = n;
      end
      @(posedge clk); #1;
      n++;
    end
    checkOutput("small_done_n", s_done_n, 19);
    checkOutput("small_first_write_n", first_we_n_s, 7);
    checkOutput("small_last_write_n", last_we_n_s, 18);
    checkOutput("small_write_count", wr_count_s, SNPIX);
    checkOutput("small_queue_left", exp_q_s.size(), 0);
    @(negedge clk);
    checkOutput("small_ready_after_done", s_ready, 1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
